// File: rtl/alu_cmd_issuer_if.sv
// Command, result and alu-port bundle for alu_cmd_issuer.
// res_tag exists only when ALU_ISSUE_TAG_EN is defined.
interface alu_cmd_issuer_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int TAG_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [DATA_W-1:0] data_in1;
  logic [DATA_W-1:0] data_in2;
  logic [OP_W-1:0]   operation;
  logic [DATA_W-1:0] data_out;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
`ifdef ALU_ISSUE_TAG_EN
  logic [TAG_W-1:0]  res_tag;
`endif

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    output cmd_ready,
    output data_in1, data_in2, operation,
    input  data_out,
    output res_valid, res_data,
`ifdef ALU_ISSUE_TAG_EN
    output res_tag,
`endif
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    input  cmd_ready,
    input  data_in1, data_in2, operation,
    output data_out,
    input  res_valid, res_data,
`ifdef ALU_ISSUE_TAG_EN
    input  res_tag,
`endif
    output res_ready
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands, issues them one at a time, returns results.
// Optional result tagging under macro ALU_ISSUE_TAG_EN.
module alu_cmd_issuer #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input logic              clk,
  input logic              rst,
  alu_cmd_issuer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t            state;
  logic [OP_W-1:0]   op_mem [DEPTH];
  logic [DATA_W-1:0] a_mem  [DEPTH];
  logic [DATA_W-1:0] b_mem  [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic              rdy;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [OP_W-1:0]   opr;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              push;
  logic              pop;
  logic              hsk;

`ifdef ALU_ISSUE_TAG_EN
  logic [TAG_W-1:0]  tag_mem [DEPTH];
  logic [TAG_W-1:0]  tag_cnt;
  logic [TAG_W-1:0]  iss_tag;
  logic [TAG_W-1:0]  rtag;

  assign bus.res_tag = rtag;
`endif

  assign bus.cmd_ready = rdy;
  assign bus.data_in1  = in1;
  assign bus.data_in2  = in2;
  assign bus.operation = opr;
  assign bus.res_valid = rvalid;
  assign bus.res_data  = rdata;

  assign push = bus.cmd_valid && rdy;
  assign hsk  = rvalid && bus.res_ready;
  // pops only when the FSM is ready to load, so an empty pop cannot happen
  assign pop  = (count != '0) &&
                ((state == IDLE) || ((state == HOLD) && hsk));
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr] <= bus.cmd_op;
      a_mem[wr_ptr]  <= bus.cmd_a;
      b_mem[wr_ptr]  <= bus.cmd_b;
`ifdef ALU_ISSUE_TAG_EN
      tag_mem[wr_ptr] <= tag_cnt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy    <= 1'b0;
      in1    <= '0;
      in2    <= '0;
      opr    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
`ifdef ALU_ISSUE_TAG_EN
      tag_cnt <= '0;
      iss_tag <= '0;
      rtag    <= '0;
`endif
    end else begin
      count <= count_nxt;
      rdy   <= (count_nxt != CW'(DEPTH));
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
`ifdef ALU_ISSUE_TAG_EN
        tag_cnt <= tag_cnt + 1'b1;
`endif
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        in1    <= a_mem[rd_ptr];
        in2    <= b_mem[rd_ptr];
        opr    <= op_mem[rd_ptr];
`ifdef ALU_ISSUE_TAG_EN
        iss_tag <= tag_mem[rd_ptr];
`endif
      end
      unique case (state)
        IDLE: begin
          if (pop) state <= ISSUE;
        end
        ISSUE: begin
          rdata  <= bus.data_out;
          rvalid <= 1'b1;
`ifdef ALU_ISSUE_TAG_EN
          rtag   <= iss_tag;
`endif
          state  <= HOLD;
        end
        HOLD: begin
          if (hsk) begin
            rvalid <= 1'b0;
            state  <= pop ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural alu on the issue ports.
// Define ALU_ISSUE_TAG_EN to also exercise result tags.
module tb_alu_cmd_issuer;
  localparam int DW = 8;
  localparam int OW = 4;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.DATA_W(DW), .OP_W(OW), .TAG_W(TW)) bus ();

  alu_cmd_issuer #(
    .DATA_W(DW), .OP_W(OW), .DEPTH(4), .TAG_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic logic [7:0] alu_f(
    input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~a;
      4'h6: r = a << 1;
      4'h7: r = a >> 1;
      4'h8: r = a + 8'd1;
      4'h9: r = a - 8'd1;
      4'hA: r = b;
      4'hB: r = a;
      4'hC: r = ~(a & b);
      4'hD: r = ~(a | b);
      4'hE: r = (a < b) ? 8'd1 : 8'd0;
      default: r = (a == b) ? 8'd1 : 8'd0;
    endcase
    return r;
  endfunction

  assign bus.data_out = alu_f(bus.operation, bus.data_in1, bus.data_in2);

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_res = 0;
  logic [7:0]    exp_q[$];
  logic [TW-1:0] exp_tag_q[$];
  int            hs_cyc[$];
  logic [TW-1:0] tag_ctr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // a handshake seen at the negedge completes at the following posedge
  always @(negedge clk) begin
    if (rst && bus.res_valid && bus.res_ready) begin
      n_res++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("res_unexpected", 32'(exp_q.size()), 1);
      end else begin
        check("res_data", bus.res_data, exp_q.pop_front());
`ifdef ALU_ISSUE_TAG_EN
        check("res_tag", bus.res_tag, exp_tag_q.pop_front());
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.cmd_op = op;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        exp_q.push_back(alu_f(op, a, b));
        exp_tag_q.push_back(tag_ctr);
        tag_ctr = tag_ctr + 1'b1;
        tick();
        break;
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!ok) check("send_timeout", 32'(bus.cmd_ready), 1);
  endtask

  task automatic wait_res(input int target);
    for (int i = 0; i < 500 && n_res < target; i++) tick();
    check("wait_res", n_res, target);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    exp_q.delete();
    exp_tag_q.delete();
    tag_ctr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

  int base;
  int hb;

  initial begin
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 4'h2;
    bus.cmd_a = 8'hAA;
    bus.cmd_b = 8'h55;
    bus.res_ready = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_din1", bus.data_in1, 0);
    check("rst_din2", bus.data_in2, 0);
    check("rst_op", bus.operation, 0);
    check("rst_res_data", bus.res_data, 0);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("post_rst_ready", bus.cmd_ready, 1);
    tick();
    check("no_cmd_taken", bus.res_valid, 0);
    check("no_cmd_din1", bus.data_in1, 0);

    // single command: CF | B0 = FF
    bus.res_ready = 1'b1;
    base = n_res;
    send(4'h3, 8'hCF, 8'hB0);
    tick();
    check("single_din1", bus.data_in1, 8'hCF);
    check("single_din2", bus.data_in2, 8'hB0);
    check("single_op", bus.operation, 4'h3);
    check("single_valid_n1", bus.res_valid, 0);
    tick();
    check("single_valid_n2", bus.res_valid, 1);
    check("single_data", bus.res_data, 8'hFF);
    tick();
    check("single_done", bus.res_valid, 0);
    check("ports_hold", bus.data_in1, 8'hCF);
    wait_res(base + 1);

    // backpressure: one in flight plus four queued fills the FIFO
    bus.res_ready = 1'b0;
    base = n_res;
    for (int i = 0; i < 5; i++) send(4'(i), 8'h5A, 8'h3C);
    check("bp_full", bus.cmd_ready, 0);
    check("bp_valid", bus.res_valid, 1);
    check("bp_data", bus.res_data, 8'h96);
    repeat (3) tick();
    check("bp_stable", bus.res_data, 8'h96);
    check("bp_still_full", bus.cmd_ready, 0);
    bus.res_ready = 1'b1;
    tick();
    check("bp_slot_free", bus.cmd_ready, 1);
    wait_res(base + 5);

    // streaming with random ops
    base = n_res;
    hb = hs_cyc.size();
    for (int i = 0; i < 10; i++)
      send(4'($urandom_range(15, 0)), 8'($urandom), 8'($urandom));
    wait_res(base + 10);
    if (hs_cyc.size() >= hb + 10)
      check("stream_span", 32'(hs_cyc[hb+9] - hs_cyc[hb]), 18);
    else
      check("stream_count", 32'(hs_cyc.size() - hb), 10);

    // reset while a result is held and commands are queued
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'h1, 8'(8'h40 + i), 8'h10);
    check("mid_hold", bus.res_valid, 1);
    do_reset();
    check("mid_rst_valid", bus.res_valid, 0);
    check("mid_rst_ready", bus.cmd_ready, 0);
    check("mid_rst_din1", bus.data_in1, 0);
    rst = 1'b1;
    tick();
    check("mid_ready", bus.cmd_ready, 1);
    tick();
    check("mid_empty_valid", bus.res_valid, 0);
    check("mid_empty_din1", bus.data_in1, 0);
    base = n_res;
    bus.res_ready = 1'b1;
    send(4'h0, 8'h01, 8'h02);
    wait_res(base + 1);
    repeat (6) tick();
    check("mid_no_extra", n_res, base + 1);
    check("mid_data", bus.res_data, 8'h03);

`ifdef ALU_ISSUE_TAG_EN
    do_reset();
    rst = 1'b1;
    tick();
    base = n_res;
    for (int i = 0; i < 18; i++) send(4'(i % 16), 8'(i * 7), 8'(i + 3));
    wait_res(base + 18);
    check("tag_final", bus.res_tag, 1);
`endif

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
